lx32_branch_ctrl: RTL

Branch resolution controller for the LX32 execute stage. It accepts one branch request at a time from issue over a valid/ready handshake and evaluates the `branch_op_e` condition on registered operands. It then compares the outcome against the front-end prediction and, on a mispredict, drives a one-cycle redirect followed by a multi-cycle pipeline flush. It also keeps saturating branch and mispredict counters for performance monitoring.

---
 rtl/lx32_branch_pkg.sv | 57 +++++
 rtl/lx32_branch_cmp.sv | 16 +
 rtl/lx32_branch_ctrl.sv | 125 ++++++++++++
 3 files changed

// File: rtl/lx32_branch_pkg.sv
// Shared types for the LX32 branch resolution controller.
// Holds the branch op encoding, the FSM state type, the captured request
// record and the branch condition function used by the comparator.
package lx32_branch_pkg;

   // Datapath width of the captured request record.
   localparam int LX32_XLEN = 32;

   // Encodings 6 and 7 are deliberately left unnamed; they resolve as illegal.
   typedef enum logic [2:0] {
      BR_EQ  = 3'd0,
      BR_NE  = 3'd1,
      BR_LT  = 3'd2,
      BR_GE  = 3'd3,
      BR_LTU = 3'd4,
      BR_GEU = 3'd5
   } branch_op_e;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESOLVE = 2'd1,
      FLUSH   = 2'd2
   } branch_state_e;

   typedef struct packed {
      branch_op_e             op;
      logic [LX32_XLEN-1:0]   a;
      logic [LX32_XLEN-1:0]   b;
      logic [LX32_XLEN-1:0]   pc;
      logic [LX32_XLEN-1:0]   imm;
      logic                   pred_taken;
      logic [LX32_XLEN-1:0]   pred_target;
   } branch_req_t;

   // Returns {taken, illegal}. Illegal ops resolve not-taken.
   function automatic logic [1:0] branch_cond(
      input branch_op_e           op,
      input logic [LX32_XLEN-1:0] a,
      input logic [LX32_XLEN-1:0] b
   );
      logic taken;
      logic illegal;
      taken   = 1'b0;
      illegal = 1'b0;
      case (op)
         BR_EQ:   taken = (a == b);
         BR_NE:   taken = (a != b);
         BR_LT:   taken = ($signed(a) <  $signed(b));
         BR_GE:   taken = ($signed(a) >= $signed(b));
         BR_LTU:  taken = (a <  b);
         BR_GEU:  taken = (a >= b);
         default: illegal = 1'b1;
      endcase
      return {taken, illegal};
   endfunction

endpackage

// File: rtl/lx32_branch_cmp.sv
// Combinational branch condition evaluator (zero latency, no state).
// Ports: op/a/b in; taken, illegal out.
// No handshake; the caller holds its inputs stable while it samples the result.
module lx32_branch_cmp
   import lx32_branch_pkg::*;
(
   input  branch_op_e           op,
   input  logic [LX32_XLEN-1:0] a,
   input  logic [LX32_XLEN-1:0] b,
   output logic                 taken,
   output logic                 illegal
);

   assign {taken, illegal} = branch_cond(op, a, b);

endmodule

// File: rtl/lx32_branch_ctrl.sv
// Branch resolution controller: captures one request, resolves it, redirects
// and flushes on mispredict. Result one cycle after handshake, flush after that.
// Ports: req_* valid/ready in, res_* / redirect_* / flush out, perf counters out.
// Backpressure: req_ready is only high in IDLE (and never while rst is high).
module lx32_branch_ctrl
   import lx32_branch_pkg::*;
#(
   // The captured request record is LX32_XLEN wide; XLEN must match it.
   parameter int XLEN         = LX32_XLEN,
   parameter int FLUSH_CYCLES = 2,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             req_valid,
   output logic             req_ready,
   input  logic [2:0]       req_op,
   input  logic [XLEN-1:0]  req_a,
   input  logic [XLEN-1:0]  req_b,
   input  logic [XLEN-1:0]  req_pc,
   input  logic [XLEN-1:0]  req_imm,
   input  logic             req_pred_taken,
   input  logic [XLEN-1:0]  req_pred_target,
   output logic             res_valid,
   output logic             res_taken,
   output logic [XLEN-1:0]  res_target,
   output logic             res_illegal,
   output logic             redirect_valid,
   output logic [XLEN-1:0]  redirect_pc,
   output logic             flush,
   output logic [CNT_W-1:0] branch_cnt,
   output logic [CNT_W-1:0] mispred_cnt
);

   branch_state_e state_q;
   branch_req_t   req_q;
   logic [3:0]    flush_cnt_q;

   logic            cmp_taken;
   logic            cmp_illegal;
   logic [XLEN-1:0] taken_tgt;
   logic [XLEN-1:0] seq_tgt;
   logic [XLEN-1:0] resolved_tgt;
   logic            mispred;
   logic            in_resolve;

   lx32_branch_cmp u_cmp (
      .op      (req_q.op),
      .a       (req_q.a),
      .b       (req_q.b),
      .taken   (cmp_taken),
      .illegal (cmp_illegal)
   );

   // Both targets wrap modulo 2^XLEN; no alignment check.
   assign taken_tgt    = req_q.pc + req_q.imm;
   assign seq_tgt      = req_q.pc + XLEN'(4);
   assign resolved_tgt = cmp_taken ? taken_tgt : seq_tgt;

   // A correctly predicted direction can still be wrong on the target.
   assign mispred = (cmp_taken != req_q.pred_taken) ||
                    (cmp_taken && req_q.pred_taken && (taken_tgt != req_q.pred_target));

   assign in_resolve = (state_q == RESOLVE);

   // Result fields are forced to zero outside RESOLVE so that every output
   // reads zero after reset, even though the cleared holding registers would
   // otherwise compare as an equal (taken) BEQ.
   assign req_ready      = (state_q == IDLE) && !rst;
   assign res_valid      = in_resolve;
   assign res_taken      = in_resolve && cmp_taken;
   assign res_illegal    = in_resolve && cmp_illegal;
   assign res_target     = in_resolve ? resolved_tgt : '0;
   assign redirect_valid = in_resolve && mispred;
   assign redirect_pc    = (in_resolve && mispred) ? resolved_tgt : '0;
   assign flush          = (state_q == FLUSH);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         req_q       <= '0;
         flush_cnt_q <= '0;
         branch_cnt  <= '0;
         mispred_cnt <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_q.op          <= branch_op_e'(req_op);
                  req_q.a           <= req_a;
                  req_q.b           <= req_b;
                  req_q.pc          <= req_pc;
                  req_q.imm         <= req_imm;
                  req_q.pred_taken  <= req_pred_taken;
                  req_q.pred_target <= req_pred_target;
                  state_q           <= RESOLVE;
               end
            end
            RESOLVE: begin
               if (branch_cnt != '1) begin
                  branch_cnt <= branch_cnt + CNT_W'(1);
               end
               if (mispred) begin
                  if (mispred_cnt != '1) begin
                     mispred_cnt <= mispred_cnt + CNT_W'(1);
                  end
                  flush_cnt_q <= 4'(FLUSH_CYCLES);
                  state_q     <= FLUSH;
               end else begin
                  state_q <= IDLE;
               end
            end
            FLUSH: begin
               // Counter holds the flush cycles remaining including this one.
               if (flush_cnt_q == 4'd1) begin
                  state_q <= IDLE;
               end
               flush_cnt_q <= flush_cnt_q - 4'd1;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

endmodule
